// File: rtl/adder_rr_arbiter_if.sv
// Request/response bundle for the shared three-operand adder.
// The arbiter sits on the slave side; requesters and the consumer use master.
interface adder_rr_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int W     = 3
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ*W-1:0] req_a;
    logic [N_REQ*W-1:0] req_b;
    logic [N_REQ*W-1:0] req_c;
    logic [N_REQ-1:0]   req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [W+1:0]       rsp_sum;
    logic [IDW-1:0]     rsp_id;
    logic               rsp_ovf;
    logic [7:0]         ovf_cnt;

    modport master (
        output req_valid, req_a, req_b, req_c, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_id, rsp_ovf, ovf_cnt
    );

    modport slave (
        input  req_valid, req_a, req_b, req_c, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_id, rsp_ovf, ovf_cnt
    );
endinterface

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one a+b+c adder among N_REQ requesters.
// One-entry registered result stage, tagged with the winning index.
module adder_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    adder_rr_arbiter_if.slave bus
);
    localparam int IDW = $clog2(N_REQ);
    localparam int SW  = W + 2;
    localparam logic [SW-1:0]  MAXW = SW'((1 << W) - 1);
    localparam logic [IDW-1:0] LAST = IDW'(N_REQ - 1);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win;
    logic [IDW:0]   idx;
    logic           found;
    logic           accept;
    logic           grant;
    logic [W-1:0]   sa;
    logic [W-1:0]   sb;
    logic [W-1:0]   sc;
    logic [SW-1:0]  sum;

    // Take a new result when empty or draining; reset holds grants off.
    assign accept = rst_n && (state == EMPTY || bus.rsp_ready);
    assign grant  = accept && found;
    assign bus.rsp_valid = (state == FULL);

    // Rotating-priority search starting at ptr.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(N_REQ))
                idx = idx - (IDW+1)'(N_REQ);
            if (!found && bus.req_valid[idx[IDW-1:0]]) begin
                found = 1'b1;
                win   = idx[IDW-1:0];
            end
        end
    end

    // One-hot grant, independent of the operand values.
    always_comb begin
        bus.req_ready = '0;
        if (grant)
            bus.req_ready[win] = 1'b1;
    end

    // Steer the winner's operands into the full-width adder.
    always_comb begin
        sa = '0;
        sb = '0;
        sc = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (IDW'(k) == win) begin
                sa = bus.req_a[k*W +: W];
                sb = bus.req_b[k*W +: W];
                sc = bus.req_c[k*W +: W];
            end
        end
        sum = SW'(sa) + SW'(sb) + SW'(sc);
    end

    // Result register, EMPTY/FULL state, pointer and overflow counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            ptr         <= '0;
            bus.rsp_sum <= '0;
            bus.rsp_id  <= '0;
            bus.rsp_ovf <= 1'b0;
            bus.ovf_cnt <= '0;
        end else if (grant) begin
            state       <= FULL;
            bus.rsp_sum <= sum;
            bus.rsp_id  <= win;
            bus.rsp_ovf <= (sum > MAXW);
            ptr         <= (win == LAST) ? '0 : win + IDW'(1);
            if (sum > MAXW && bus.ovf_cnt != 8'hFF)
                bus.ovf_cnt <= bus.ovf_cnt + 8'd1;
        end else if (state == FULL && bus.rsp_ready) begin
            state <= EMPTY;
        end
    end
endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter with N_REQ=4, W=3.
// Expected values are hand-computed constants.
module tb_adder_rr_arbiter;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    adder_rr_arbiter_if #(.N_REQ(4), .W(3)) bus();

    adder_rr_arbiter #(.N_REQ(4), .W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [2:0] a,
                          input logic [2:0] b, input logic [2:0] c);
        bus.req_a[i*3 +: 3] = a;
        bus.req_b[i*3 +: 3] = b;
        bus.req_c[i*3 +: 3] = c;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_c = '0;
        bus.rsp_ready = 1'b0;

        // reset and idle
        #12;
        check("rst_valid", 32'(bus.rsp_valid), 0);
        check("rst_sum", 32'(bus.rsp_sum), 0);
        check("rst_id", 32'(bus.rsp_id), 0);
        check("rst_ovf", 32'(bus.rsp_ovf), 0);
        check("rst_cnt", 32'(bus.ovf_cnt), 0);
        check("rst_ready", 32'(bus.req_ready), 0);
        rst_n = 1'b1;
        tick();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_valid", 32'(bus.rsp_valid), 0);
        end

        // single request from requester 2
        set_op(2, 3'd1, 3'd2, 3'd3);
        bus.req_valid = 4'b0100;
        #1;
        check("single_ready", 32'(bus.req_ready), 32'b0100);
        tick();
        bus.req_valid = '0;
        check("single_valid", 32'(bus.rsp_valid), 1);
        check("single_sum", 32'(bus.rsp_sum), 6);
        check("single_id", 32'(bus.rsp_id), 2);
        check("single_ovf", 32'(bus.rsp_ovf), 0);
        tick();
        check("single_drain", 32'(bus.rsp_valid), 0);

        // round-robin with all requesters valid
        pulse_reset();
        for (int i = 0; i < 4; i++)
            set_op(i, 3'(i), 3'(i), 3'(i));
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("rr_ready", 32'(bus.req_ready), 32'(1 << (i % 4)));
            tick();
            check("rr_id", 32'(bus.rsp_id), 32'(i % 4));
            check("rr_sum", 32'(bus.rsp_sum), 32'(3 * (i % 4)));
        end
        bus.req_valid = '0;

        // backpressure
        pulse_reset();
        set_op(0, 3'd5, 3'd2, 3'd1);
        set_op(1, 3'd1, 3'd1, 3'd1);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b0001;
        tick();
        check("bp_sum0", 32'(bus.rsp_sum), 8);
        check("bp_ovf0", 32'(bus.rsp_ovf), 1);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0010;
        for (int j = 0; j < 3; j++) begin
            #1;
            check("bp_stall_ready", 32'(bus.req_ready), 0);
            tick();
            check("bp_hold_valid", 32'(bus.rsp_valid), 1);
            check("bp_hold_sum", 32'(bus.rsp_sum), 8);
            check("bp_hold_id", 32'(bus.rsp_id), 0);
            check("bp_hold_ovf", 32'(bus.rsp_ovf), 1);
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_ready", 32'(bus.req_ready), 32'b0010);
        tick();
        bus.req_valid = '0;
        check("bp_id1", 32'(bus.rsp_id), 1);
        check("bp_sum1", 32'(bus.rsp_sum), 3);
        check("bp_ovf1", 32'(bus.rsp_ovf), 0);
        check("bp_cnt", 32'(bus.ovf_cnt), 1);

        // overflow counter saturation
        pulse_reset();
        set_op(0, 3'd7, 3'd7, 3'd7);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b0001;
        for (int n = 1; n <= 260; n++) begin
            tick();
            check("sat_sum", 32'(bus.rsp_sum), 21);
            check("sat_ovf", 32'(bus.rsp_ovf), 1);
            if (n == 1)
                check("sat_cnt1", 32'(bus.ovf_cnt), 1);
            if (n == 255)
                check("sat_cnt255", 32'(bus.ovf_cnt), 255);
        end
        check("sat_cnt_end", 32'(bus.ovf_cnt), 255);

        // reset mid-transfer with ptr away from 0
        set_op(2, 3'd1, 3'd2, 3'd3);
        bus.req_valid = 4'b0100;
        tick();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        tick();
        check("mid_pre_valid", 32'(bus.rsp_valid), 1);
        check("mid_pre_id", 32'(bus.rsp_id), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_valid", 32'(bus.rsp_valid), 0);
        check("mid_sum", 32'(bus.rsp_sum), 0);
        check("mid_cnt", 32'(bus.ovf_cnt), 0);
        set_op(0, 3'd1, 3'd1, 3'd2);
        set_op(3, 3'd3, 3'd3, 3'd3);
        bus.req_valid = 4'b1001;
        bus.rsp_ready = 1'b1;
        #1;
        check("mid_rst_ready", 32'(bus.req_ready), 0);
        rst_n = 1'b1;
        #1;
        check("mid_ready", 32'(bus.req_ready), 32'b0001);
        tick();
        check("mid_id", 32'(bus.rsp_id), 0);
        check("mid_sum0", 32'(bus.rsp_sum), 4);
        bus.req_valid = 4'b1000;
        #1;
        check("mid_next_ready", 32'(bus.req_ready), 32'b1000);
        tick();
        bus.req_valid = '0;
        check("mid_id3", 32'(bus.rsp_id), 3);
        check("mid_sum3", 32'(bus.rsp_sum), 9);
        check("mid_ovf3", 32'(bus.rsp_ovf), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
